// File: rtl/dds_wave_gen_if.sv
// Control and sample bundle for the DDS waveform generator.
// The master side (register bank / testbench) drives the tuning word, duty and
// shape select. The slave side (dds_wave_gen) returns the DAC sample, its valid
// strobe and the phase-wrap pulse.
interface dds_wave_gen_if #(
    parameter int DATA_W = 10
);
    logic              run;
    logic              phase_clr;
    logic [31:0]       inc_phi;
    logic [3:0]        occupation;
    logic [3:0]        waveform;
    logic [DATA_W-1:0] dac_data;
    logic              dac_valid;
    logic              wrap;

    modport master (
        output run, phase_clr, inc_phi, occupation, waveform,
        input  dac_data, dac_valid, wrap
    );

    modport slave (
        input  run, phase_clr, inc_phi, occupation, waveform,
        output dac_data, dac_valid, wrap
    );
endinterface

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS waveform generator.
// A 32-bit accumulator advances by the tuning word on every run cycle. The
// registered output stage turns the phase held before each edge into an
// offset-binary sample (DC, square, ramp up/down, triangle).
// Optional build macro PARAM_SHADOW_EN: the tuning word, duty and shape are
// captured in shadow registers that update only at a phase wrap, on phase_clr,
// or right after reset release, so parameter changes are period-aligned.
module dds_wave_gen #(
    parameter int DATA_W = 10
) (
    input  logic           clk,
    input  logic           reset,
    dds_wave_gen_if.slave  bus
);

    localparam logic [DATA_W-1:0] MID_C = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_C = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ZERO_C = {DATA_W{1'b0}};

    logic [31:0]       phase_q,    phase_d;
    logic              wrap_q,     wrap_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              dac_valid_q, dac_valid_d;

    logic [31:0]       inc_act;
    logic [3:0]        occ_act;
    logic [3:0]        wave_act;
    logic [32:0]       sum_s;
    logic [DATA_W-1:0] sample_s;

`ifdef PARAM_SHADOW_EN
    logic [31:0] inc_sh_q,  inc_sh_d;
    logic [3:0]  occ_sh_q,  occ_sh_d;
    logic [3:0]  wave_sh_q, wave_sh_d;
    logic        rel_q,     rel_d;
    logic        load_s;

    // Effective parameters: live inputs on the first cycle out of reset, shadows otherwise.
    always_comb begin
        if (rel_q) begin
            inc_act  = bus.inc_phi;
            occ_act  = bus.occupation;
            wave_act = bus.waveform;
        end else begin
            inc_act  = inc_sh_q;
            occ_act  = occ_sh_q;
            wave_act = wave_sh_q;
        end
    end

    // Shadow load on wrap carry, phase clear, or the cycle right after reset release.
    always_comb begin
        load_s    = rel_q | bus.phase_clr | (bus.run & sum_s[32]);
        rel_d     = 1'b0;
        inc_sh_d  = inc_sh_q;
        occ_sh_d  = occ_sh_q;
        wave_sh_d = wave_sh_q;
        if (load_s) begin
            inc_sh_d  = bus.inc_phi;
            occ_sh_d  = bus.occupation;
            wave_sh_d = bus.waveform;
        end else begin
            inc_sh_d  = inc_sh_q;
            occ_sh_d  = occ_sh_q;
            wave_sh_d = wave_sh_q;
        end
    end

    // Shadow registers; reset clears them and arms the release-load flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            inc_sh_q  <= 32'd0;
            occ_sh_q  <= 4'd0;
            wave_sh_q <= 4'd0;
            rel_q     <= 1'b1;
        end else begin
            inc_sh_q  <= inc_sh_d;
            occ_sh_q  <= occ_sh_d;
            wave_sh_q <= wave_sh_d;
            rel_q     <= rel_d;
        end
    end
`else
    // Parameters pass straight through; a change is seen on the next edge.
    always_comb begin
        inc_act  = bus.inc_phi;
        occ_act  = bus.occupation;
        wave_act = bus.waveform;
    end
`endif

    // Accumulator sum with carry out of bit 31 kept as the wrap indication.
    always_comb begin
        sum_s = {1'b0, phase_q} + {1'b0, inc_act};
    end

    // Shape decode from the phase held before the edge (one-cycle latency).
    always_comb begin
        sample_s = MID_C;
        case (wave_act)
            4'd0: sample_s = MID_C;
            4'd1: begin
                if (phase_q[31:28] < occ_act) begin
                    sample_s = MAX_C;
                end else begin
                    sample_s = ZERO_C;
                end
            end
            4'd2: sample_s = phase_q[31 -: DATA_W];
            4'd3: sample_s = ~phase_q[31 -: DATA_W];
            4'd4: begin
                if (phase_q[31]) begin
                    sample_s = ~phase_q[30 -: DATA_W];
                end else begin
                    sample_s = phase_q[30 -: DATA_W];
                end
            end
            default: sample_s = MID_C;
        endcase
    end

    // Next-state: clear beats accumulate; a frozen accumulator never wraps.
    always_comb begin
        phase_d     = phase_q;
        wrap_d      = 1'b0;
        dac_valid_d = bus.run & ~bus.phase_clr;
        dac_data_d  = dac_data_q;
        if (bus.phase_clr) begin
            phase_d = 32'd0;
            wrap_d  = 1'b0;
        end else if (bus.run) begin
            phase_d = sum_s[31:0];
            wrap_d  = sum_s[32];
        end else begin
            phase_d = phase_q;
            wrap_d  = 1'b0;
        end
        if (dac_valid_d) begin
            dac_data_d = sample_s;
        end else begin
            dac_data_d = dac_data_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= 32'd0;
            wrap_q      <= 1'b0;
            dac_data_q  <= ZERO_C;
            dac_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            wrap_q      <= wrap_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
        end
    end

    assign bus.dac_data  = dac_data_q;
    assign bus.dac_valid = dac_valid_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen (default build, DATA_W = 10).
// A behavioural model tracks the phase as an integer modulo 2^32 and derives
// each expected sample arithmetically from the waveform rules.
module tb_dds_wave_gen;

    localparam int DW = 10;
    localparam longint TWO32 = 64'h1_0000_0000;
    localparam longint TWO31 = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    longint      m_phase;
    logic [DW-1:0] m_data;
    logic        m_valid;
    logic        m_wrap;

    dds_wave_gen_if #(.DATA_W(DW)) bus ();

    dds_wave_gen #(.DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_sample(longint ph, int wf, int occ);
        longint top;
        longint tri_v;
        top = ph / (TWO32 / 1024);
        case (wf)
            1: return ((ph / 64'h1000_0000) < occ) ? 10'd1023 : 10'd0;
            2: return DW'(top);
            3: return DW'(1023 - top);
            4: begin
                tri_v = ((ph * 2) % TWO32) / (TWO32 / 1024);
                if (ph >= TWO31) return DW'(1023 - tri_v);
                else return DW'(tri_v);
            end
            default: return 10'd512;
        endcase
    endfunction

    task automatic check(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then compare.
    task automatic step();
        longint sum;
        @(posedge clk);
        if (reset) begin
            m_phase = 0;
            m_data  = '0;
            m_valid = 1'b0;
            m_wrap  = 1'b0;
        end else begin
            m_valid = bus.run && !bus.phase_clr;
            if (m_valid) m_data = ref_sample(m_phase, int'(bus.waveform), int'(bus.occupation));
            if (bus.phase_clr) begin
                m_phase = 0;
                m_wrap  = 1'b0;
            end else if (bus.run) begin
                sum     = m_phase + longint'(bus.inc_phi);
                m_wrap  = (sum >= TWO32);
                m_phase = sum % TWO32;
            end else begin
                m_wrap = 1'b0;
            end
        end
        #1;
        check("dac_data", longint'(bus.dac_data), longint'(m_data));
        check("dac_valid", longint'(bus.dac_valid), longint'(m_valid));
        check("wrap", longint'(bus.wrap), longint'(m_wrap));
    endtask

    initial begin
        logic [DW-1:0] held;
        reset          = 1'b1;
        bus.run        = 1'b0;
        bus.phase_clr  = 1'b0;
        bus.inc_phi    = 32'd0;
        bus.occupation = 4'd0;
        bus.waveform   = 4'd0;
        m_phase = 0; m_data = '0; m_valid = 1'b0; m_wrap = 1'b0;

        // Reset for three cycles: all outputs zero.
        repeat (3) step();
        check("rst_data", longint'(bus.dac_data), 0);
        check("rst_valid", longint'(bus.dac_valid), 0);

        // Ramp up at 1/16 of the clock: 0,64,...,960 with wrap on the 16th sample.
        reset = 1'b0; bus.run = 1'b1; bus.inc_phi = 32'h1000_0000; bus.waveform = 4'd2;
        for (int k = 0; k < 32; k++) begin
            step();
            check("ramp_seq", longint'(bus.dac_data), longint'((k % 16) * 64));
            check("ramp_wrap", longint'(bus.wrap), longint'((k % 16) == 15));
        end

        // Square at 50% duty: 8 samples high, 8 low.
        bus.waveform = 4'd1; bus.occupation = 4'd8;
        for (int k = 0; k < 32; k++) begin
            step();
            check("sq50", longint'(bus.dac_data), ((k % 16) < 8) ? 1023 : 0);
        end
        // 0% duty keeps the output at zero.
        bus.occupation = 4'd0;
        for (int k = 0; k < 16; k++) begin
            step();
            check("sq0", longint'(bus.dac_data), 0);
        end

        // Triangle with a 32-sample period; peak on the phase[31] boundary.
        bus.waveform = 4'd4; bus.inc_phi = 32'h0800_0000;
        for (int k = 0; k < 32; k++) begin
            step();
            check("tri", longint'(bus.dac_data), (k < 16) ? k * 64 : 1023 - (k - 16) * 64);
        end

        // Nyquist toggle on ramp.
        bus.waveform = 4'd2; bus.inc_phi = 32'h8000_0000;
        repeat (6) step();
        // DC, reserved code, ramp down and inc_phi=0 static output.
        bus.inc_phi = 32'h0123_4567; bus.waveform = 4'd0; repeat (4) step();
        bus.waveform = 4'd9;  repeat (4) step();
        bus.waveform = 4'd3;  repeat (8) step();
        bus.inc_phi = 32'd0;  repeat (6) step();

        // run 1-0-0-1: samples hold with valid low, then resume without a skip.
        bus.waveform = 4'd2; bus.inc_phi = 32'h1000_0000;
        repeat (5) step();
        held = bus.dac_data;
        bus.run = 1'b0;
        repeat (2) begin
            step();
            check("gap_hold", longint'(bus.dac_data), longint'(held));
            check("gap_valid", longint'(bus.dac_valid), 0);
        end
        bus.run = 1'b1;
        step();
        check("resume", longint'(bus.dac_data), longint'(held) + 64);
        // phase_clr mid-ramp: next sample restarts at 0.
        repeat (3) step();
        bus.phase_clr = 1'b1;
        step();
        check("clr_valid", longint'(bus.dac_valid), 0);
        bus.phase_clr = 1'b0;
        step();
        check("clr_restart", longint'(bus.dac_data), 0);
        step();
        check("clr_next", longint'(bus.dac_data), 64);

        // One-cycle reset mid-ramp.
        repeat (4) step();
        reset = 1'b1;
        step();
        check("mid_rst_data", longint'(bus.dac_data), 0);
        check("mid_rst_wrap", longint'(bus.wrap), 0);
        reset = 1'b0;
        step();
        check("rst_restart", longint'(bus.dac_data), 0);

        // Randomised stimulus against the model.
        for (int k = 0; k < 600; k++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.run        = ($urandom_range(0, 9) != 0);
            bus.phase_clr  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.inc_phi = ($urandom_range(0, 1) == 1) ? $urandom() : ($urandom() >> 4);
            end
            if ($urandom_range(0, 19) == 0) bus.waveform = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) bus.occupation = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
